// File: rtl/cheri_dmem_responder_pkg.sv
// Shared types for the CHERI data-memory responder: response queue entry,
// sizing limits and the byte-merge helper used on partial writes.
package cheri_pkg;

    localparam int MaxRespLatency = 4;
    localparam int MaxDepth       = 8;
    localparam int CountW         = $clog2(MaxRespLatency);

    typedef struct packed {
        logic              valid;
        logic [CountW-1:0] countdown;
        logic              err;
        logic              is_cap;
        logic [32:0]       rdata;
    } resp_entry_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/cheri_dmem_responder_if.sv
// Core-side data bus of the CHERI memory responder, including the grant throttle.
interface cheri_dmem_responder_if;

    logic        data_req_i;
    logic        data_is_cap_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [32:0] data_wdata_i;
    logic        stall_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [32:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i,
               data_wdata_i, stall_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i,
               data_wdata_i, stall_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

endinterface

// File: rtl/cheri_dmem_responder_resp_fifo.sv
// In-order response queue: every entry counts down from RespLatency-1 and the
// head is presented (and popped) once its countdown reaches zero.
module cheri_dmem_resp_fifo
    import cheri_pkg::*;
#(
    parameter int Depth       = 4,
    parameter int RespLatency = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push,
    input  resp_entry_t push_entry,
    output logic        full,
    output logic        rvalid,
    output logic [32:0] rdata,
    output logic        err
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CountW-1:0] LoadCount = CountW'(RespLatency - 1);

    resp_entry_t     entries [Depth];
    resp_entry_t     head;
    resp_entry_t     load_entry;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;
    logic            pop;

    assign head   = entries[rd_ptr];
    assign full   = (count == CntW'(Depth));
    assign pop    = head.valid && (head.countdown == '0);
    assign rvalid = pop && !rst_i;
    assign rdata  = rvalid ? head.rdata : '0;
    assign err    = rvalid && head.err;

    always_comb begin
        load_entry           = push_entry;
        load_entry.valid     = 1'b1;
        load_entry.countdown = LoadCount;
    end

    // All entries share one latency, so the head always finishes first and
    // order is preserved without any per-entry search.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                entries[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (entries[i].valid && entries[i].countdown != '0) begin
                    entries[i].countdown <= entries[i].countdown - 1'b1;
                end
            end
            if (pop) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= load_entry;
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full));
            assert (!(pop && head.err && head.rdata != '0));
        end
    end

endmodule

// File: rtl/cheri_dmem_responder.sv
// Tagged data memory behind the core data bus: range check, byte-masked
// writes with tag clearing on partial stores, and fixed-latency responses.
module cheri_dmem_responder
    import cheri_pkg::*;
#(
    parameter logic [31:0] BaseAddr    = 32'h8000_0000,
    parameter int          MemWords    = 1024,
    parameter int          RespLatency = 1,
    parameter int          Depth       = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    cheri_dmem_responder_if.slave  bus
);

    localparam int          AddrW = $clog2(MemWords);
    localparam logic [32:0] Span  = 33'(4 * MemWords);

    logic [31:0]       mem_data [MemWords];
    logic [MemWords-1:0] mem_tag;
    logic              full;
    logic              gnt;
    logic              in_range;
    logic              do_write;
    logic [32:0]       offset;
    logic [AddrW-1:0]  index;
    resp_entry_t       push_entry;

    // A 33-bit difference makes addresses below BaseAddr land far above Span,
    // so one unsigned compare covers both bounds without wrapping at 2^32.
    assign offset   = {1'b0, bus.data_addr_i & 32'hFFFF_FFFC} - {1'b0, BaseAddr};
    assign in_range = (offset < Span);
    assign index    = offset[AddrW+1:2];

    assign gnt            = bus.data_req_i && !bus.stall_i && !full && !rst_i;
    assign bus.data_gnt_o = gnt;
    assign do_write       = gnt && in_range && bus.data_we_i;

    always_comb begin
        push_entry        = '0;
        push_entry.err    = !in_range;
        push_entry.is_cap = bus.data_is_cap_i;
        if (in_range && !bus.data_we_i) begin
            push_entry.rdata = {mem_tag[index], mem_data[index]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_data[index] <= merge_bytes(mem_data[index], bus.data_wdata_i[31:0], bus.data_be_i);
        end
    end

    // Only a full-word store can carry a valid capability; anything narrower
    // would leave a forged capability behind, so it clears the tag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_tag <= '0;
        end else if (do_write) begin
            mem_tag[index] <= (bus.data_be_i == 4'hF) && bus.data_wdata_i[32];
        end
    end

    cheri_dmem_resp_fifo #(
        .Depth       (Depth),
        .RespLatency (RespLatency)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (gnt),
        .push_entry (push_entry),
        .full       (full),
        .rvalid     (bus.data_rvalid_o),
        .rdata      (bus.data_rdata_o),
        .err        (bus.data_err_o)
    );

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// Scoreboard bench: instance A (latency 1) covers data/tag/range behaviour,
// instance B (latency 4, depth 4) covers back-pressure, ordering and reset flush.
module tb_cheri_dmem_responder;

    localparam logic [31:0] Base  = 32'h8000_0000;
    localparam int          Words = 16;

    typedef struct {
        logic [32:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    cheri_dmem_responder_if bus_a ();
    cheri_dmem_responder_if bus_b ();

    cheri_dmem_responder #(
        .BaseAddr(Base), .MemWords(Words), .RespLatency(1), .Depth(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst_a), .bus(bus_a)
    );

    cheri_dmem_responder #(
        .BaseAddr(Base), .MemWords(Words), .RespLatency(4), .Depth(4)
    ) dut_b (
        .clk_i(clk), .rst_i(rst_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Response monitors: pop the oldest expectation whenever rvalid is seen.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.data_rvalid_o) begin
            if (q_a.size() == 0) begin
                checkOutput("a_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = q_a.pop_front();
                checkOutput("a_rdata", 64'(bus_a.data_rdata_o), 64'(e.rdata));
                checkOutput("a_err", 64'(bus_a.data_err_o), 64'(e.err));
                checkOutput("a_latency", 64'(cyc), 64'(e.due));
            end
        end else if (bus_a.data_rdata_o != '0 || bus_a.data_err_o) begin
            checkOutput("a_idle_outputs", 64'({bus_a.data_rdata_o, bus_a.data_err_o}), 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.data_rvalid_o) begin
            if (q_b.size() == 0) begin
                checkOutput("b_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = q_b.pop_front();
                checkOutput("b_rdata", 64'(bus_b.data_rdata_o), 64'(e.rdata));
                checkOutput("b_err", 64'(bus_b.data_err_o), 64'(e.err));
                checkOutput("b_latency", 64'(cyc), 64'(e.due));
            end
        end else if (bus_b.data_rdata_o != '0 || bus_b.data_err_o) begin
            checkOutput("b_idle_outputs", 64'({bus_b.data_rdata_o, bus_b.data_err_o}), 64'd0);
        end
    end

    // One request on instance A, optionally stalled first; grant is expected
    // in the first unstalled cycle since a latency-1 queue never fills here.
    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [32:0] wdata, input int stall_cycles,
                                 input logic [32:0] exp_rdata, input logic exp_err);
        exp_t e;
        bus_a.data_req_i    = 1'b1;
        bus_a.data_we_i     = we;
        bus_a.data_be_i     = be;
        bus_a.data_addr_i   = addr;
        bus_a.data_wdata_i  = wdata;
        bus_a.data_is_cap_i = (be == 4'hF);
        for (int i = 0; i <= stall_cycles; i++) begin
            bus_a.stall_i = (i < stall_cycles);
            @(negedge clk);
            if (i < stall_cycles) begin
                checkOutput("a_gnt_stalled", 64'(bus_a.data_gnt_o), 64'd0);
            end else begin
                checkOutput("a_gnt", 64'(bus_a.data_gnt_o), 64'd1);
                if (bus_a.data_gnt_o) begin
                    e.rdata = exp_rdata;
                    e.err   = exp_err;
                    e.due   = cyc + 1;
                    q_a.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        bus_a.data_req_i = 1'b0;
        bus_a.stall_i    = 1'b0;
    endtask

    function automatic logic [32:0] bWord(input int k);
        return {k[0], 32'h5A5A_0000 | 32'(k)};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        exp_t e;
        int   k;
        logic [7:0] gnt_pattern;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.data_req_i = 1'b1; bus_a.data_is_cap_i = 1'b0; bus_a.data_we_i = 1'b0;
        bus_a.data_be_i = 4'hF;  bus_a.data_addr_i = Base;   bus_a.data_wdata_i = '0;
        bus_a.stall_i = 1'b0;
        bus_b.data_req_i = 1'b0; bus_b.data_is_cap_i = 1'b0; bus_b.data_we_i = 1'b0;
        bus_b.data_be_i = 4'hF;  bus_b.data_addr_i = Base;   bus_b.data_wdata_i = '0;
        bus_b.stall_i = 1'b0;

        $display("[TB] reset phase");
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_gnt", 64'(bus_a.data_gnt_o), 64'd0);
            checkOutput("rst_rvalid", 64'(bus_a.data_rvalid_o), 64'd0);
            checkOutput("rst_rdata_err", 64'({bus_a.data_rdata_o, bus_a.data_err_o}), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.data_req_i = 1'b0;

        $display("[TB] instance A: data, tag and range");
        applyStimulus(1'b0, 4'hF, Base,              33'h0,           0, 33'h0,           1'b0);
        applyStimulus(1'b1, 4'hF, Base + 32'd4,      33'h1_DEAD_BEEF, 0, 33'h0,           1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd4,      33'h0,           0, 33'h1_DEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 4'h1, Base + 32'd4,      33'h0_0000_0000, 0, 33'h0,           1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd4,      33'h0,           0, 33'h0_DEAD_BE00, 1'b0);
        applyStimulus(1'b1, 4'hF, Base + 32'd8,      33'h0_AABB_CCDD, 0, 33'h0,           1'b0);
        applyStimulus(1'b1, 4'h6, Base + 32'd8,      33'h1_1122_3344, 0, 33'h0,           1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd8,      33'h0,           0, 33'h0_AA22_33DD, 1'b0);
        applyStimulus(1'b1, 4'hF, Base + 32'd60,     33'h1_CAFE_F00D, 0, 33'h0,           1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd60,     33'h0,           0, 33'h1_CAFE_F00D, 1'b0);
        applyStimulus(1'b1, 4'hF, Base + 32'd64,     33'h1_FFFF_FFFF, 0, 33'h0,           1'b1);
        applyStimulus(1'b0, 4'hF, Base + 32'd64,     33'h0,           0, 33'h0,           1'b1);
        applyStimulus(1'b1, 4'hF, Base - 32'd4,      33'h1_FFFF_FFFF, 0, 33'h0,           1'b1);
        applyStimulus(1'b0, 4'hF, Base - 32'd4,      33'h0,           0, 33'h0,           1'b1);
        applyStimulus(1'b0, 4'hF, 32'hFFFF_FFFC,     33'h0,           0, 33'h0,           1'b1);
        applyStimulus(1'b0, 4'hF, Base,              33'h0,           0, 33'h0,           1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd60,     33'h0,           0, 33'h1_CAFE_F00D, 1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd7,      33'h0,           3, 33'h0_DEAD_BE00, 1'b0);
        applyStimulus(1'b1, 4'h0, Base + 32'd60,     33'h1_1234_5678, 0, 33'h0,           1'b0);
        applyStimulus(1'b0, 4'hF, Base + 32'd60,     33'h0,           0, 33'h0_CAFE_F00D, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("a_drained", 64'(q_a.size()), 64'd0);

        $display("[TB] instance B: back-pressure and ordering");
        gnt_pattern = 8'hEF;
        k = 0;
        bus_b.data_req_i = 1'b1;
        bus_b.data_we_i  = 1'b1;
        bus_b.data_be_i  = 4'hF;
        for (int i = 0; i < 8; i++) begin
            bus_b.data_addr_i  = Base + 32'(4 * k);
            bus_b.data_wdata_i = bWord(k);
            @(negedge clk);
            checkOutput("b_gnt_pattern", 64'(bus_b.data_gnt_o), 64'(gnt_pattern[i]));
            if (bus_b.data_gnt_o) begin
                e.rdata = '0;
                e.err   = 1'b0;
                e.due   = cyc + 4;
                q_b.push_back(e);
                k++;
            end
            @(posedge clk);
            #1;
        end
        bus_b.data_req_i = 1'b0;
        checkOutput("b_grant_count", 64'(k), 64'd7);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("b_writes_drained", 64'(q_b.size()), 64'd0);

        bus_b.data_req_i = 1'b1;
        bus_b.data_we_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_b.data_addr_i = Base + 32'(4 * i);
            @(negedge clk);
            checkOutput("b_read_gnt", 64'(bus_b.data_gnt_o), 64'd1);
            if (bus_b.data_gnt_o) begin
                e.rdata = bWord(i);
                e.err   = 1'b0;
                e.due   = cyc + 4;
                q_b.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        bus_b.data_req_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b_reads_drained", 64'(q_b.size()), 64'd0);

        $display("[TB] instance B: reset with responses in flight");
        bus_b.data_req_i  = 1'b1;
        bus_b.data_addr_i = Base + 32'd4;
        repeat (2) begin
            @(negedge clk);
            checkOutput("b_pre_reset_gnt", 64'(bus_b.data_gnt_o), 64'd1);
            @(posedge clk);
            #1;
        end
        rst_b = 1'b1;
        q_b.delete();
        repeat (2) begin
            @(negedge clk);
            checkOutput("b_rst_gnt", 64'(bus_b.data_gnt_o), 64'd0);
            checkOutput("b_rst_rvalid", 64'(bus_b.data_rvalid_o), 64'd0);
            checkOutput("b_rst_rdata_err", 64'({bus_b.data_rdata_o, bus_b.data_err_o}), 64'd0);
            @(posedge clk);
            #1;
        end
        rst_b = 1'b0;
        bus_b.data_req_i = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("b_post_reset_rvalid", 64'(bus_b.data_rvalid_o), 64'd0);
        end
        @(posedge clk);
        #1;

        // Word 1 was written with its tag set; reset clears tags but keeps data.
        bus_b.data_req_i  = 1'b1;
        bus_b.data_addr_i = Base + 32'd4;
        @(negedge clk);
        checkOutput("b_tag_read_gnt", 64'(bus_b.data_gnt_o), 64'd1);
        if (bus_b.data_gnt_o) begin
            e.rdata = 33'h0_5A5A_0001;
            e.err   = 1'b0;
            e.due   = cyc + 4;
            q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        bus_b.data_req_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b_final_drained", 64'(q_b.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cheri_dmem_responder.md
CHERI_DMEM_RESPONDER -- requirements
Module: cheri_dmem_responder

Interface
REQ-001 SHALL have parameter BaseAddr, default 32'h8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter MemWords, default 1024, number of 33-bit words; power of two, 16..65536.
REQ-003 SHALL have parameter RespLatency, default 1, cycles from grant to rvalid; legal range 1..4.
REQ-004 SHALL have parameter Depth, default 4, maximum outstanding responses; legal range 1..8.
REQ-005 SHALL have port clk_i, input, 1, sole clock; one clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port data_req_i, input, 1, core request valid.
REQ-008 SHALL have port data_is_cap_i, input, 1, capability-word access marker.
REQ-009 SHALL have port data_we_i, input, 1, write enable.
REQ-010 SHALL have port data_be_i, input, 4, byte enables.
REQ-011 SHALL have port data_addr_i, input, 32, byte address; bits [1:0] ignored.
REQ-012 SHALL have port data_wdata_i, input, 33, write data; bit 32 is the capability tag.
REQ-013 SHALL have port stall_i, input, 1, testbench grant throttle.
REQ-014 SHALL have port data_gnt_o, output, 1, request accepted.
REQ-015 SHALL have port data_rvalid_o, output, 1, response valid.
REQ-016 SHALL have port data_rdata_o, output, 33, read data with tag in bit 32.
REQ-017 SHALL have port data_err_o, output, 1, bus error, qualified by data_rvalid_o.

Function
REQ-018 SHALL drive data_gnt_o = data_req_i & ~stall_i & ~full, combinationally; full = Depth entries outstanding.
REQ-019 SHALL not grant when full even if a response retires in the same cycle.
REQ-020 SHALL treat an access as in range iff BaseAddr <= addr < BaseAddr + 4*MemWords, computed in 33 bits (no wrap at 2^32).
REQ-021 SHALL, on granted in-range write, update bytes selected by data_be_i in the grant cycle.
REQ-022 SHALL write tag = data_wdata_i[32] only when data_be_i == 4'hF; any other write (including be == 0) SHALL clear the word's tag.
REQ-023 SHALL, on granted in-range read, sample the word and tag in the grant cycle; a write granted in an earlier cycle SHALL be visible.
REQ-024 SHALL, on granted out-of-range access, perform no memory update and queue an error response with rdata 0.
REQ-025 SHALL return write responses with data_rdata_o = 0, data_err_o = 0.
REQ-026 SHALL assert data_rvalid_o exactly RespLatency cycles after the grant cycle, for one cycle per request, in grant order.
REQ-027 SHALL sustain one grant and one response per cycle in steady state (back-to-back).
REQ-028 SHALL hold data_rdata_o and data_err_o at 0 whenever data_rvalid_o is 0.
REQ-029 SHALL ignore data_is_cap_i functionally except for recording it per queue entry for assertions.
REQ-030 SHALL implement each queue entry as {valid, countdown, err, rdata}; countdown loads RespLatency-1 on push, decrements each cycle while nonzero, and the head pops when countdown == 0.

Reset
REQ-031 SHALL, while rst_i is high, clear the queue, drive data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0, and clear all tag bits.
REQ-032 SHALL drop responses in flight when rst_i asserts mid-operation; no rvalid for them after reset.
REQ-033 SHALL not reset data word contents; data_gnt_o SHALL be 0 while rst_i is high.

Structure
REQ-034 SHALL place the resp_entry_t typedef and the MaxRespLatency/MaxDepth constants in the shared package cheri_pkg.
REQ-035 SHALL implement the response queue as sub-module cheri_dmem_resp_fifo; memory array and range check live in the top.

Verification
REQ-036 Read at BaseAddr after reset, RespLatency=1 -> gnt same cycle, rvalid next cycle, rdata 33'h0 (tag clear), err 0.
REQ-037 Write 33'h1_DEAD_BEEF be=4'hF to BaseAddr+4, then byte write be=4'h1 0x00 to same, read -> rdata 33'h0_DEAD_BE00.
REQ-038 Access to BaseAddr+4*MemWords and to BaseAddr-4 -> rvalid with err=1, rdata 0, memory unchanged.
REQ-039 Depth=4, RespLatency=4, req held high 8 cycles -> 4 grants, gnt low until first pop, responses in grant order.
REQ-040 stall_i high 3 cycles with req high -> no gnt; rst_i pulsed with 2 responses pending -> no rvalid afterwards, outputs 0.
